// File: rtl/ir_code_player.sv
// IR code sequencer: loads carrier compare from a ROM record, then gates the carrier through its on/off pair list (IR_PLAYER_REPEAT_EN enables list repeats).
// Latency: 2 cycles per ROM word fetch; each phase lasts D*TICK_DIV cycles, fetch cycles excluded.
// Backpressure: none; start ignored while busy, abort returns to idle on the next cycle.
module ir_code_player #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int CARRIER_WIDTH = 8,
    parameter int TICK_DIV      = 120
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    input  logic [ADDR_WIDTH-1:0]    start_addr_in,
    output logic [ADDR_WIDTH-1:0]    rom_addr_out,
    input  logic [DATA_WIDTH-1:0]    rom_data_in,
    output logic                     carrier_enable_out,
    output logic [CARRIER_WIDTH-1:0] carrier_compare_out,
    output logic                     carrier_update_out,
    output logic                     busy_out,
    output logic                     done_out
);
    localparam int              PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_RELOAD = PW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_CARRIER, S_FETCH_COUNT, S_LOAD,
        S_FETCH_ON, S_ON, S_FETCH_OFF, S_OFF, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic                    capture;
    logic                    take;
    logic                    advance, rewind;
    logic                    phase_end, list_end, data_zero, nxt_is_fetch;
    logic [ADDR_WIDTH-1:0]   base_addr, fetch_addr, pair_ofs;
    logic [11:0]             pair_cnt, pair_idx, pair_idx_nxt;
    logic [DATA_WIDTH-1:0]  dur_cnt;
    logic [PW-1:0]           presc_cnt;
`ifdef IR_PLAYER_REPEAT_EN
    logic [3:0]              rep_left;
`endif

    // capture marks the second fetch cycle, when rom_data_in holds the word
    assign take         = capture && !abort_in;
    assign data_zero    = (rom_data_in == '0);
    assign phase_end    = (presc_cnt == '0) && (dur_cnt == DATA_WIDTH'(1));
    assign list_end     = ((pair_idx + 12'd1) == pair_cnt);
    assign nxt_is_fetch = state_nxt inside {S_FETCH_CARRIER, S_FETCH_COUNT, S_FETCH_ON, S_FETCH_OFF};

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pair_idx_nxt = pair_idx;
        advance      = 1'b0;
        rewind       = 1'b0;
        case (state)
            S_IDLE:          if (start_in) begin
                                 state_nxt    = S_FETCH_CARRIER;
                                 pair_idx_nxt = '0;
                             end
            S_FETCH_CARRIER: if (capture) state_nxt = S_FETCH_COUNT;
            S_FETCH_COUNT:   if (capture) state_nxt = (rom_data_in[11:0] == 12'd0) ? S_DONE : S_LOAD;
            S_LOAD:          state_nxt = S_FETCH_ON;
            S_FETCH_ON:      if (capture) state_nxt = data_zero ? S_FETCH_OFF : S_ON;
            S_ON:            if (phase_end) state_nxt = S_FETCH_OFF;
            S_FETCH_OFF:     if (capture) begin
                                 if (data_zero) advance   = 1'b1;
                                 else           state_nxt = S_OFF;
                             end
            S_OFF:           if (phase_end) advance = 1'b1;
            S_DONE:          state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
        if (advance) begin
            if (!list_end) begin
                pair_idx_nxt = pair_idx + 12'd1;
                state_nxt    = S_FETCH_ON;
            end
`ifdef IR_PLAYER_REPEAT_EN
            else if (rep_left != 4'd0) begin
                rewind       = 1'b1;
                pair_idx_nxt = '0;
                state_nxt    = S_FETCH_ON;
            end
`endif
            else begin
                state_nxt = S_DONE;
            end
        end
        if (abort_in && state != S_IDLE) begin
            state_nxt    = S_IDLE;
            pair_idx_nxt = pair_idx;
            rewind       = 1'b0;
        end
    end

    always_comb begin
        carrier_enable_out = (state == S_ON);
        carrier_update_out = (state == S_LOAD);
        busy_out           = (state != S_IDLE);
        done_out           = (state == S_DONE);
    end

    always_comb begin
        pair_ofs   = ADDR_WIDTH'({pair_idx_nxt, 1'b0});
        fetch_addr = rom_addr_out;
        case (state_nxt)
            S_FETCH_CARRIER: fetch_addr = start_addr_in;
            S_FETCH_COUNT:   fetch_addr = base_addr + ADDR_WIDTH'(1);
            S_FETCH_ON:      fetch_addr = base_addr + ADDR_WIDTH'(2) + pair_ofs;
            S_FETCH_OFF:     fetch_addr = base_addr + ADDR_WIDTH'(3) + pair_ofs;
            default:         fetch_addr = rom_addr_out;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            capture             <= 1'b0;
            rom_addr_out        <= '0;
            base_addr           <= '0;
            pair_idx            <= '0;
            pair_cnt            <= '0;
            carrier_compare_out <= '0;
            dur_cnt             <= '0;
            presc_cnt           <= '0;
`ifdef IR_PLAYER_REPEAT_EN
            rep_left            <= '0;
`endif
        end else begin
            capture  <= (state_nxt == state) &&
                        (state inside {S_FETCH_CARRIER, S_FETCH_COUNT, S_FETCH_ON, S_FETCH_OFF});
            pair_idx <= pair_idx_nxt;
            if (nxt_is_fetch && state_nxt != state) rom_addr_out <= fetch_addr;
            if (state == S_IDLE && start_in) base_addr <= start_addr_in;
            if (state == S_FETCH_CARRIER && take) carrier_compare_out <= rom_data_in[CARRIER_WIDTH-1:0];
            if (state == S_FETCH_COUNT && take) begin
                pair_cnt <= rom_data_in[11:0];
`ifdef IR_PLAYER_REPEAT_EN
                rep_left <= rom_data_in[15:12];
`endif
            end
`ifdef IR_PLAYER_REPEAT_EN
            if (rewind) rep_left <= rep_left - 4'd1;
`endif
            // prescaler reloads at every phase start; duration counts whole ticks down to 1
            if ((state == S_FETCH_ON || state == S_FETCH_OFF) && take) begin
                dur_cnt   <= rom_data_in;
                presc_cnt <= PRESC_RELOAD;
            end else if (state == S_ON || state == S_OFF) begin
                if (presc_cnt == '0) begin
                    presc_cnt <= PRESC_RELOAD;
                    dur_cnt   <= dur_cnt - DATA_WIDTH'(1);
                end else begin
                    presc_cnt <= presc_cnt - PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ir_code_player.sv
// Directed bench for ir_code_player with TICK_DIV=4 and a synchronous ROM model.
module tb_ir_code_player;
    logic        clock_in = 1'b0;
    logic        reset_n_in;
    logic        start_in, abort_in;
    logic [9:0]  start_addr_in, rom_addr_out;
    logic [15:0] rom_data_in;
    logic        carrier_enable_out, carrier_update_out, busy_out, done_out;
    logic [7:0]  carrier_compare_out;

    logic [15:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    int hi_start[$];
    int hi_len[$];
    int n_upd, upd_cmp, upd_en, n_done, done_cyc;

    ir_code_player #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .CARRIER_WIDTH(8), .TICK_DIV(4)) dut (
        .clock_in(clock_in), .reset_n_in(reset_n_in),
        .start_in(start_in), .abort_in(abort_in), .start_addr_in(start_addr_in),
        .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
        .carrier_enable_out(carrier_enable_out), .carrier_compare_out(carrier_compare_out),
        .carrier_update_out(carrier_update_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) rom_data_in <= mem[rom_addr_out];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_rec(input logic [9:0] addr);
        @(negedge clock_in);
        start_in      = 1'b1;
        start_addr_in = addr;
    endtask

    // Sample every cycle after start until busy drops; cycle 1 is the first cycle with busy expected high.
    task automatic watch(input string tg, input int max_cyc, input int restart_cyc);
        int  run;
        bit  ended;
        run = 0; ended = 0;
        hi_start.delete(); hi_len.delete();
        n_upd = 0; upd_cmp = -1; upd_en = -1; n_done = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= max_cyc && !ended; cyc++) begin
            @(negedge clock_in);
            start_in      = (cyc == restart_cyc);
            start_addr_in = (cyc == restart_cyc) ? 10'h100 : start_addr_in;
            if (carrier_enable_out) begin
                if (run == 0) hi_start.push_back(cyc);
                run++;
            end else if (run != 0) begin
                hi_len.push_back(run);
                run = 0;
            end
            if (carrier_update_out) begin
                n_upd++;
                upd_cmp = carrier_compare_out;
                upd_en  = carrier_enable_out;
            end
            if (done_out) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy_out) ended = 1;
        end
        start_in = 1'b0;
        if (!ended) chk({tg, "_timeout"}, 1, 0);
    endtask

    task automatic check_basic(input string tg);
        watch(tg, 200, 10);
        chk({tg, "_nupd"},   n_upd, 1);
        chk({tg, "_updcmp"}, upd_cmp, 32'h1A);
        chk({tg, "_upden"},  upd_en, 0);
        chk({tg, "_nhi"},    hi_len.size(), 2);
        chk({tg, "_hi0st"},  hi_start[0], 8);
        chk({tg, "_hi0len"}, hi_len[0], 12);
        chk({tg, "_hi1st"},  hi_start[1], 32);
        chk({tg, "_hi1len"}, hi_len[1], 4);
        chk({tg, "_ndone"},  n_done, 1);
        chk({tg, "_donecyc"}, done_cyc, 38);
        chk({tg, "_cmpkeep"}, carrier_compare_out, 32'h1A);
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[10'h010] = 16'h001A; mem[10'h011] = 16'h0002;
        mem[10'h012] = 16'd3;    mem[10'h013] = 16'd2;
        mem[10'h014] = 16'd1;    mem[10'h015] = 16'd0;
        mem[10'h100] = 16'h0055; mem[10'h101] = 16'h0000;
        mem[10'h200] = 16'h0033; mem[10'h201] = 16'h0001;
        mem[10'h202] = 16'd0;    mem[10'h203] = 16'd5;
        mem[10'h300] = 16'h0044; mem[10'h301] = 16'h0001;
        mem[10'h302] = 16'd100;  mem[10'h303] = 16'd1;
        mem[10'h380] = 16'h0021; mem[10'h381] = 16'h2001;
        mem[10'h382] = 16'd1;    mem[10'h383] = 16'd1;

        reset_n_in = 1'b0; start_in = 1'b0; abort_in = 1'b0; start_addr_in = '0;
        repeat (3) @(negedge clock_in);
        chk("rst_en",   carrier_enable_out, 0);
        chk("rst_upd",  carrier_update_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_cmp",  carrier_compare_out, 0);
        chk("rst_addr", rom_addr_out, 0);
        reset_n_in = 1'b1;
        @(negedge clock_in);

        // main record, with a start pulse mid-run that must be ignored
        start_rec(10'h010);
        check_basic("t1");

        // empty pair list, with abort alongside start in idle
        start_rec(10'h100);
        abort_in = 1'b1;
        @(negedge clock_in);
        abort_in = 1'b0;
        start_in = 1'b0;
        chk("n0_busy", busy_out, 1);
        watch("n0", 50, 0);
        chk("n0_nupd",    n_upd, 0);
        chk("n0_nhi",     hi_len.size(), 0);
        chk("n0_donecyc", done_cyc + 1, 5);
        chk("n0_cmp",     carrier_compare_out, 32'h55);

        // zero-length on phase
        start_rec(10'h200);
        watch("z", 100, 0);
        chk("z_nhi",     hi_len.size(), 0);
        chk("z_nupd",    n_upd, 1);
        chk("z_donecyc", done_cyc, 30);

        // abort mid-ON, with a competing start
        start_rec(10'h300);
        @(negedge clock_in);
        start_in = 1'b0;
        repeat (49) @(negedge clock_in);
        chk("ab_midon", carrier_enable_out, 1);
        abort_in = 1'b1;
        start_in = 1'b1;
        @(negedge clock_in);
        abort_in = 1'b0;
        start_in = 1'b0;
        chk("ab_en",   carrier_enable_out, 0);
        chk("ab_busy", busy_out, 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_out || busy_out) nd++;
            @(negedge clock_in);
        end
        chk("ab_quiet", nd, 0);
        chk("ab_cmp",   carrier_compare_out, 32'h44);
        start_rec(10'h010);
        check_basic("t1b");

        // asynchronous reset mid-OFF
        start_rec(10'h010);
        @(negedge clock_in);
        start_in = 1'b0;
        repeat (23) @(negedge clock_in);
        chk("rs_midoff", {busy_out, carrier_enable_out}, 2'b10);
        #2 reset_n_in = 1'b0;
        #1;
        chk("rs_en",   carrier_enable_out, 0);
        chk("rs_busy", busy_out, 0);
        chk("rs_cmp",  carrier_compare_out, 0);
        chk("rs_addr", rom_addr_out, 0);
        @(negedge clock_in);
        start_in = 1'b1;
        start_addr_in = 10'h010;
        @(negedge clock_in);
        start_in = 1'b0;
        chk("rs_ignored", busy_out, 0);
        reset_n_in = 1'b1;
        @(negedge clock_in);
        chk("rs_idle", busy_out, 0);

        // repeat-count field
        start_rec(10'h380);
        watch("rp", 200, 0);
        chk("rp_nupd", n_upd, 1);
        chk("rp_ndone", n_done, 1);
        chk("rp_hilen", hi_len[0], 4);
`ifdef IR_PLAYER_REPEAT_EN
        chk("rp_nhi",     hi_len.size(), 3);
        chk("rp_hi2st",   hi_start[2], 32);
        chk("rp_donecyc", done_cyc, 42);
`else
        chk("rp_nhi",     hi_len.size(), 1);
        chk("rp_donecyc", done_cyc, 18);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
